// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame receiver and its holding register.
package serial_frame_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Even-parity bit for a word zero-extended to MAX_WIDTH.
    function automatic logic parity_of(input logic [MAX_WIDTH-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/serial_frame_hold.sv
// One-word valid/ready holding register; flags a sticky overflow when a
// completed word arrives while the held word is not being drained.
module serial_frame_hold
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_perr,
    input  logic             dout_rdy,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             par_err,
    output logic             ovf
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;
    logic             perr_q, perr_d;
    logic             ovf_q, ovf_d;

    logic take;
    logic accept;
    logic drop;

    // A word draining this cycle frees the slot for a word landing this cycle.
    always_comb begin
        take   = vld_q & dout_rdy;
        accept = load_vld & (~vld_q | take);
        drop   = load_vld & ~accept;
        data_d = accept ? load_data : data_q;
        perr_d = accept ? load_perr : perr_q;
        vld_d  = accept | (vld_q & ~take);
        ovf_d  = drop | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            perr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            perr_q <= perr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign dout     = data_q;
    assign dout_vld = vld_q;
    assign par_err  = perr_q;
    assign ovf      = ovf_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB-first, optional even
// parity bit; completed words go to a one-word valid/ready holding register.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             par_err,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             busy
);

    localparam int              CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] shift_in;
    logic             word_done;
    logic [WIDTH-1:0] word_data;
    logic             word_perr;

    assign shift_in = {shift_q[WIDTH-2:0], din};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Invalid cycles leave everything untouched, which gives the stall behaviour.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (din_vld && din) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (din_vld) begin
                    shift_d = shift_in;
                    if (cnt_q == LAST_BIT) begin
                        if (PARITY_EN) begin
                            state_d = PARITY;
                            cnt_d   = cnt_q + CW'(1);
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (din_vld) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        word_done = 1'b0;
        word_data = shift_q;
        word_perr = 1'b0;
        case (state_q)
            DATA: begin
                if (din_vld && (cnt_q == LAST_BIT) && !PARITY_EN) begin
                    word_done = 1'b1;
                    word_data = shift_in;
                end
            end
            PARITY: begin
                if (din_vld) begin
                    word_done = 1'b1;
                    word_perr = din ^ parity_of(MAX_WIDTH'(shift_q));
                end
            end
            default: ;
        endcase
    end

    serial_frame_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load_vld  (word_done),
        .load_data (word_data),
        .load_perr (word_perr),
        .dout_rdy  (dout_rdy),
        .ovf_clr   (ovf_clr),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .par_err   (par_err),
        .ovf       (ovf)
    );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: a parity build and a no-parity build, each checked
// every cycle against a frame-level model, plus hand-computed spot checks.
module tb_serial_frame_rx;
    import serial_frame_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din_a  [2];
    logic         vld_a  [2];
    logic         rdy_a  [2];
    logic         clr_a  [2];
    logic [W-1:0] dout_a [2];
    logic         dvld_a [2];
    logic         perr_a [2];
    logic         ovf_a  [2];
    logic         busy_a [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    serial_frame_rx #(.WIDTH(W), .PARITY_EN(1'b1)) dut_par (
        .clk(clk), .rst(rst), .din(din_a[0]), .din_vld(vld_a[0]),
        .dout(dout_a[0]), .dout_vld(dvld_a[0]), .dout_rdy(rdy_a[0]),
        .par_err(perr_a[0]), .ovf(ovf_a[0]), .ovf_clr(clr_a[0]), .busy(busy_a[0])
    );

    serial_frame_rx #(.WIDTH(W), .PARITY_EN(1'b0)) dut_nopar (
        .clk(clk), .rst(rst), .din(din_a[1]), .din_vld(vld_a[1]),
        .dout(dout_a[1]), .dout_vld(dvld_a[1]), .dout_rdy(rdy_a[1]),
        .par_err(perr_a[1]), .ovf(ovf_a[1]), .ovf_clr(clr_a[1]), .busy(busy_a[1])
    );

    // Frame-level model: the bits of the current frame in arrival order, then the held word.
    typedef struct packed {
        logic       inframe;
        logic [3:0] n;
        logic [8:0] bits;
        logic       vld;
        logic [7:0] dout;
        logic       perr;
        logic       ovf;
    } model_t;

    model_t m [2];

    function automatic model_t step(model_t s, bit pen, logic d, logic v, logic rdy, logic clr);
        model_t     r;
        logic       done;
        logic       take;
        logic [8:0] nb;
        logic [7:0] w;
        logic       pe;
        int         need;
        int         ones;
        r    = s;
        done = 1'b0;
        w    = '0;
        pe   = 1'b0;
        need = pen ? W + 1 : W;
        take = s.vld & rdy;
        if (!s.inframe) begin
            if (v && d) begin
                r.inframe = 1'b1;
                r.n       = '0;
                r.bits    = '0;
            end
        end else if (v) begin
            nb      = s.bits;
            nb[s.n] = d;
            r.bits  = nb;
            r.n     = 4'(int'(s.n) + 1);
            if (int'(s.n) + 1 == need) begin
                done      = 1'b1;
                r.inframe = 1'b0;
                r.n       = '0;
                for (int i = 0; i < W; i++) w[W-1-i] = nb[i];
                if (pen) begin
                    ones = 0;
                    for (int i = 0; i <= W; i++) ones += int'(nb[i]);
                    pe = (ones % 2) != 0;
                end
            end
        end
        if (done && (!s.vld || take)) begin
            r.vld  = 1'b1;
            r.dout = w;
            r.perr = pe;
        end else if (take) begin
            r.vld = 1'b0;
        end
        if (done && s.vld && !take) r.ovf = 1'b1;
        else if (clr)               r.ovf = 1'b0;
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m[0] <= '0;
            m[1] <= '0;
        end else begin
            m[0] <= step(m[0], 1'b1, din_a[0], vld_a[0], rdy_a[0], clr_a[0]);
            m[1] <= step(m[1], 1'b0, din_a[1], vld_a[1], rdy_a[1], clr_a[1]);
        end
    end

    task automatic check_output(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s dut%0d: got %0h want %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 2; k++) begin
                check_output("busy", k, 32'(busy_a[k]), 32'(m[k].inframe));
                check_output("dout_vld", k, 32'(dvld_a[k]), 32'(m[k].vld));
                check_output("ovf", k, 32'(ovf_a[k]), 32'(m[k].ovf));
                if (m[k].vld) begin
                    check_output("dout", k, 32'(dout_a[k]), 32'(m[k].dout));
                    check_output("par_err", k, 32'(perr_a[k]), 32'(m[k].perr));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int k, input logic b, input int gap);
        din_a[k] = b;
        vld_a[k] = 1'b1;
        tick();
        vld_a[k] = 1'b0;
        din_a[k] = 1'b0;
        clr_a[k] = 1'b0;
        repeat (gap) tick();
    endtask

    // Data (and parity) bits; the final bit carries the optional rdy/clr changes.
    task automatic send_body(input int k, input logic [7:0] w, input bit pen, input logic pbit,
                             input int gap, input bit set_rdy, input bit set_clr);
        for (int i = W - 1; i >= 0; i--) begin
            if (i == 0 && !pen) begin
                if (set_rdy) rdy_a[k] = 1'b1;
                if (set_clr) clr_a[k] = 1'b1;
                apply_stimulus(k, w[i], 0);
            end else begin
                apply_stimulus(k, w[i], gap);
            end
        end
        if (pen) begin
            if (set_rdy) rdy_a[k] = 1'b1;
            if (set_clr) clr_a[k] = 1'b1;
            apply_stimulus(k, pbit, 0);
        end
    endtask

    task automatic send_frame(input int k, input logic [7:0] w, input bit pen, input logic pbit,
                              input bit set_rdy, input bit set_clr);
        apply_stimulus(k, 1'b1, 0);
        send_body(k, w, pen, pbit, 0, set_rdy, set_clr);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            din_a[k] = 1'b0; vld_a[k] = 1'b0; rdy_a[k] = 1'b0; clr_a[k] = 1'b0;
        end
        #1 rst = 1'b0;
        cmp_on = 1'b1;

        // reset with din toggling
        vld_a[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din_a[0] = ~din_a[0];
            tick();
        end
        check_output("rst_dout", 0, 32'(dout_a[0]), 32'h0);
        check_output("rst_vld", 0, 32'(dvld_a[0]), 32'h0);
        check_output("rst_perr", 0, 32'(perr_a[0]), 32'h0);
        check_output("rst_ovf", 0, 32'(ovf_a[0]), 32'h0);
        check_output("rst_busy", 0, 32'(busy_a[0]), 32'h0);
        vld_a[0] = 1'b0;
        din_a[0] = 1'b0;
        rst = 1'b1;
        repeat (2) tick();

        // nominal 0xA5, parity 0
        rdy_a[0] = 1'b1;
        send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("a5_vld", 0, 32'(dvld_a[0]), 32'h1);
        check_output("a5_dout", 0, 32'(dout_a[0]), 32'hA5);
        check_output("a5_perr", 0, 32'(perr_a[0]), 32'h0);
        check_output("a5_model", 0, 32'(m[0].dout), 32'hA5);
        tick();
        check_output("a5_drained", 0, 32'(dvld_a[0]), 32'h0);

        // parity error on 0x3C
        send_frame(0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output("3c_dout", 0, 32'(dout_a[0]), 32'h3C);
        check_output("3c_perr", 0, 32'(perr_a[0]), 32'h1);
        check_output("3c_model_perr", 0, 32'(m[0].perr), 32'h1);
        tick();

        // same frame with two-cycle gaps between bits
        apply_stimulus(0, 1'b1, 0);
        tick();
        check_output("gap_busy_a", 0, 32'(busy_a[0]), 32'h1);
        tick();
        check_output("gap_busy_b", 0, 32'(busy_a[0]), 32'h1);
        send_body(0, 8'h3C, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        check_output("gap_dout", 0, 32'(dout_a[0]), 32'h3C);
        check_output("gap_perr", 0, 32'(perr_a[0]), 32'h1);
        tick();

        // back-to-back frames with rdy high
        send_frame(0, 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("b2b_first", 0, 32'(dout_a[0]), 32'h96);
        send_frame(0, 8'h69, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("b2b_second", 0, 32'(dout_a[0]), 32'h69);
        tick();

        // backpressure: 0x22 dropped while 0x11 held, drop beats ovf_clr
        rdy_a[0] = 1'b0;
        send_frame(0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        send_frame(0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("ovf_held", 0, 32'(dout_a[0]), 32'h11);
        check_output("ovf_set", 0, 32'(ovf_a[0]), 32'h1);
        clr_a[0] = 1'b1;
        tick();
        clr_a[0] = 1'b0;
        check_output("ovf_cleared", 0, 32'(ovf_a[0]), 32'h0);
        rdy_a[0] = 1'b1;
        tick();
        check_output("ovf_drain_vld", 0, 32'(dvld_a[0]), 32'h0);
        check_output("ovf_no_22", 0, 32'(dout_a[0]), 32'h11);

        // drain of 0x11 and load of 0x5A in the same cycle
        rdy_a[0] = 1'b0;
        send_frame(0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        send_frame(0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        check_output("swap_dout", 0, 32'(dout_a[0]), 32'h5A);
        check_output("swap_vld", 0, 32'(dvld_a[0]), 32'h1);
        check_output("swap_ovf", 0, 32'(ovf_a[0]), 32'h0);
        tick();

        // held word on dut0 and partial frame on dut1 both lost to reset
        rdy_a[0] = 1'b0;
        send_frame(0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        rdy_a[1] = 1'b1;
        apply_stimulus(1, 1'b1, 0);
        for (int i = 0; i < 4; i++) apply_stimulus(1, 1'b1, 0);
        check_output("mid_busy", 1, 32'(busy_a[1]), 32'h1);
        rst = 1'b0;
        tick();
        check_output("mid_rst_busy", 1, 32'(busy_a[1]), 32'h0);
        check_output("mid_rst_vld", 1, 32'(dvld_a[1]), 32'h0);
        check_output("held_discard", 0, 32'(dvld_a[0]), 32'h0);
        rst = 1'b1;
        tick();
        send_frame(1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("c3_dout", 1, 32'(dout_a[1]), 32'hC3);
        check_output("c3_vld", 1, 32'(dvld_a[1]), 32'h1);
        check_output("c3_perr", 1, 32'(perr_a[1]), 32'h0);
        check_output("c3_model", 1, 32'(m[1].dout), 32'hC3);
        repeat (3) tick();

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
